// File: rtl/latency_bench_pkg.sv
// latency_bench_pkg: state encoding, datapath widths and constants shared by the latency bench controller
package latency_bench_pkg;
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_SEND, WAIT_RECV, GAP, FINISH} state_t;
    localparam int LAT_W = 32;
    localparam int SUM_W = 48;
    localparam int RUN_W = 16;
    localparam logic [LAT_W-1:0] LAT_MIN_INIT = '1;
endpackage

// File: rtl/us_tick_gen.sv
// us_tick_gen: microsecond prescaler counting 0..CLK_PER_US-1
// Ports: clk, rst_n (sync active-low), restart (the current cycle counts as prescaler 0),
//        tick (high for one cycle on the wrap cycle)
module us_tick_gen #(
    parameter int CLK_PER_US = 125
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic tick
);
    localparam int W = CLK_PER_US > 1 ? $clog2(CLK_PER_US) : 1;
    logic [W-1:0] cnt, cur;
    assign cur = restart ? '0 : cnt;
    assign tick = cur == W'(CLK_PER_US - 1);
    always_ff @(posedge clk)
        cnt <= !rst_n ? '0 : tick ? '0 : cur + W'(1);
endmodule

// File: rtl/latency_bench_ctrl.sv
// latency_bench_ctrl: runs a send/receive latency campaign and keeps min/max/last/sum statistics in microseconds
// Ports: clk, rst_n (sync active-low); cfg_start/cfg_runs/cfg_gap_us campaign setup;
//        send_start out, send_done/recv_done in (datapath handshake);
//        busy, done, timeout_err status; lat_min/lat_max/lat_last/lat_sum/runs_done statistics
// Build option: LATENCY_BENCH_SUM_EN builds the lat_sum accumulator, otherwise lat_sum is tied to 0
module latency_bench_ctrl
    import latency_bench_pkg::*;
#(
    parameter int CLK_PER_US = 125,
    parameter int TIMEOUT_US = 1000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_start,
    input  logic [RUN_W-1:0] cfg_runs,
    input  logic [RUN_W-1:0] cfg_gap_us,
    output logic             send_start,
    input  logic             send_done,
    input  logic             recv_done,
    output logic             busy,
    output logic             done,
    output logic             timeout_err,
    output logic [LAT_W-1:0] lat_min,
    output logic [LAT_W-1:0] lat_max,
    output logic [LAT_W-1:0] lat_last,
    output logic [SUM_W-1:0] lat_sum,
    output logic [RUN_W-1:0] runs_done
);
    state_t state;
    logic [RUN_W-1:0] runs_q, gap_q;
    logic [LAT_W-1:0] us_cnt, lat;
    logic tick, restart, sd, tmo, rec, last, accept;

    assign accept = state == IDLE && cfg_start;
    assign sd = state == WAIT_SEND && send_done;
    // the limit wins over a response arriving on the same cycle
    assign tmo = (state == WAIT_SEND || state == WAIT_RECV) && us_cnt == LAT_W'(TIMEOUT_US);
    assign rec = !tmo && recv_done && (sd || state == WAIT_RECV);
    assign lat = state == WAIT_SEND ? LAT_W'(1) : us_cnt + LAT_W'(1);
    assign last = runs_done + RUN_W'(1) == runs_q;
    // timing restarts at issue (timeout base), at send_done (latency base) and at a record (gap base)
    assign restart = state == ISSUE || sd || rec;

    us_tick_gen #(.CLK_PER_US(CLK_PER_US)) u_tick (
        .clk(clk),
        .rst_n(rst_n),
        .restart(restart),
        .tick(tick)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            send_start  <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            timeout_err <= 1'b0;
            lat_min     <= LAT_MIN_INIT;
            lat_max     <= '0;
            lat_last    <= '0;
            runs_done   <= '0;
            us_cnt      <= '0;
            runs_q      <= '0;
            gap_q       <= '0;
        end else begin
            send_start <= 1'b0;
            done       <= 1'b0;
            us_cnt     <= restart ? '0 : us_cnt + LAT_W'(tick);
            if (rec) begin
                lat_last  <= lat;
                lat_min   <= lat < lat_min ? lat : lat_min;
                lat_max   <= lat > lat_max ? lat : lat_max;
                runs_done <= runs_done + RUN_W'(1);
            end
            case (state)
                IDLE: if (cfg_start) begin
                    runs_q      <= cfg_runs;
                    gap_q       <= cfg_gap_us;
                    lat_min     <= LAT_MIN_INIT;
                    lat_max     <= '0;
                    lat_last    <= '0;
                    runs_done   <= '0;
                    timeout_err <= 1'b0;
                    busy        <= 1'b1;
                    state       <= cfg_runs == '0 ? FINISH : ISSUE;
                end
                ISSUE: begin
                    send_start <= 1'b1;
                    state      <= WAIT_SEND;
                end
                WAIT_SEND, WAIT_RECV: begin
                    if (tmo) begin
                        timeout_err <= 1'b1;
                        state       <= FINISH;
                    end else if (rec) state <= last ? FINISH : GAP;
                    else if (sd) state <= WAIT_RECV;
                end
                GAP: if (us_cnt >= LAT_W'(gap_q)) state <= ISSUE;
                FINISH: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef LATENCY_BENCH_SUM_EN
    logic [SUM_W:0] sum_nxt;
    logic [SUM_W-1:0] sum_q;
    assign sum_nxt = {1'b0, sum_q} + (SUM_W + 1)'(lat);
    always_ff @(posedge clk)
        if (!rst_n || accept) sum_q <= '0;
        else if (rec) sum_q <= sum_nxt[SUM_W] ? '1 : sum_nxt[SUM_W-1:0];
    assign lat_sum = sum_q;
`else
    assign lat_sum = '0;
`endif
endmodule

// File: tb/tb_latency_bench_ctrl.sv
// tb_latency_bench_ctrl: table-driven campaigns with a latency scoreboard plus timeout, busy and reset sequences
module tb_latency_bench_ctrl;
    localparam int CLK = 125;
`ifdef LATENCY_BENCH_SUM_EN
    localparam bit SUM_EN = 1'b1;
`else
    localparam bit SUM_EN = 1'b0;
`endif
    logic clk = 1'b0, rst_n = 1'b0, cfg_start = 1'b0, send_done = 1'b0, recv_done = 1'b0;
    logic [15:0] cfg_runs = '0, cfg_gap_us = '0;
    logic send_start, busy, done, timeout_err;
    logic [31:0] lat_min, lat_max, lat_last;
    logic [47:0] lat_sum;
    logic [15:0] runs_done;
    logic [15:0] prev_runs = '0;
    int checks = 0, failures = 0, cyc = 0, ss_cnt = 0, done_cnt = 0;
    int exp_q[$];

    typedef struct {
        int runs, gap, d0, d1, d2, l0, l1, l2;
        logic [31:0] e_min, e_max, e_last;
        int e_sum;
    } vec_t;
    vec_t vecs[5];

    always #4 clk = ~clk;

    latency_bench_ctrl #(.CLK_PER_US(CLK), .TIMEOUT_US(6)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_runs(cfg_runs),
        .cfg_gap_us(cfg_gap_us), .send_start(send_start), .send_done(send_done),
        .recv_done(recv_done), .busy(busy), .done(done), .timeout_err(timeout_err),
        .lat_min(lat_min), .lat_max(lat_max), .lat_last(lat_last), .lat_sum(lat_sum),
        .runs_done(runs_done)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (send_start) ss_cnt++;
        if (done) done_cnt++;
        if (rst_n && runs_done == prev_runs + 16'd1) begin
            if (exp_q.size() == 0) check("sb_unexpected_run", {48'd0, runs_done}, {48'd0, prev_runs});
            else check("sb_lat_last", {32'd0, lat_last}, 64'(exp_q.pop_front()));
        end
        prev_runs = runs_done;
    end

    function automatic int dly_of(vec_t v, int i);
        return i == 0 ? v.d0 : i == 1 ? v.d1 : v.d2;
    endfunction

    function automatic int lat_of(vec_t v, int i);
        return i == 0 ? v.l0 : i == 1 ? v.l1 : v.l2;
    endfunction

    task automatic start_campaign(input int runs, input int gap);
        @(negedge clk);
        cfg_runs = 16'(runs);
        cfg_gap_us = 16'(gap);
        cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
    endtask

    task automatic wait_ss(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(negedge clk);
            ok = send_start;
        end
    endtask

    task automatic wait_done(input int lim, output int n);
        n = -1;
        for (int i = 1; i <= lim && n < 0; i++) begin
            @(negedge clk);
            if (done) n = i;
        end
    endtask

    task automatic pulse_done(input int d);
        send_done = 1'b1;
        if (d == 0) recv_done = 1'b1;
        @(negedge clk);
        send_done = 1'b0;
        recv_done = 1'b0;
        if (d > 0) begin
            repeat (d - 1) @(negedge clk);
            recv_done = 1'b1;
            @(negedge clk);
            recv_done = 1'b0;
        end
    endtask

    initial begin
        vec_t v;
        int n, base, last_ss, dc;
        bit ok;
        vecs[0] = '{1, 0, 250, 0, 0, 3, 0, 0, 32'd3, 32'd3, 32'd3, 3};
        vecs[1] = '{3, 2, 130, 600, 400, 2, 5, 4, 32'd2, 32'd5, 32'd4, 11};
        vecs[2] = '{2, 0, 0, 124, 0, 1, 1, 0, 32'd1, 32'd1, 32'd1, 2};
        vecs[3] = '{1, 0, 125, 0, 0, 2, 0, 0, 32'd2, 32'd2, 32'd2, 2};
        vecs[4] = '{0, 0, 0, 0, 0, 0, 0, 0, 32'hFFFF_FFFF, 32'd0, 32'd0, 0};

        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_send_start", send_start, 0);
        check("rst_lat_min", lat_min, 32'hFFFF_FFFF);
        check("rst_lat_max", lat_max, 0);
        check("rst_runs_done", runs_done, 0);
        rst_n = 1'b1;

        for (int r = 0; r < 5; r++) begin
            v = vecs[r];
            base = ss_cnt;
            last_ss = cyc;
            start_campaign(v.runs, v.gap);
            for (int i = 0; i < v.runs; i++) begin
                wait_ss(ok);
                check("send_start_seen", ok, 1);
                if (i > 0) check("gap_sep", (cyc - last_ss) >= v.gap * CLK, 1);
                last_ss = cyc;
                repeat (3) @(negedge clk);
                exp_q.push_back(lat_of(v, i));
                pulse_done(dly_of(v, i));
            end
            wait_done(3000, n);
            if (v.runs == 0) check("done_after_2_cycles", n, 1);
            else check("done_seen", n > 0, 1);
            check("vec_lat_min", lat_min, v.e_min);
            check("vec_lat_max", lat_max, v.e_max);
            check("vec_lat_last", lat_last, v.e_last);
            check("vec_lat_sum", lat_sum, SUM_EN ? 48'(v.e_sum) : 48'd0);
            check("vec_runs_done", runs_done, 16'(v.runs));
            check("vec_send_starts", ss_cnt - base, v.runs);
            check("vec_timeout_err", timeout_err, 0);
        end

        start_campaign(2, 0);
        wait_ss(ok);
        repeat (3) @(negedge clk);
        send_done = 1'b1;
        @(negedge clk);
        send_done = 1'b0;
        wait_done(3000, n);
        check("tmo_recv_done_seen", n > 0, 1);
        check("tmo_recv_err", timeout_err, 1);
        check("tmo_recv_runs_done", runs_done, 0);
        check("tmo_recv_lat_min", lat_min, 32'hFFFF_FFFF);
        start_campaign(1, 0);
        check("tmo_cleared", timeout_err, 0);
        wait_ss(ok);
        repeat (3) @(negedge clk);
        exp_q.push_back(3);
        pulse_done(250);
        wait_done(3000, n);
        check("after_tmo_lat_last", lat_last, 3);
        check("after_tmo_err", timeout_err, 0);

        start_campaign(1, 0);
        wait_ss(ok);
        wait_done(3000, n);
        check("tmo_send_err", timeout_err, 1);
        check("tmo_send_window", n > 700 && n < 800, 1);

        base = ss_cnt;
        start_campaign(1, 0);
        wait_ss(ok);
        check("busy_in_run", busy, 1);
        start_campaign(5, 3);
        repeat (2) @(negedge clk);
        exp_q.push_back(1);
        pulse_done(0);
        wait_done(3000, n);
        check("busy_ignore_done", n > 0, 1);
        check("busy_ignore_runs", runs_done, 1);
        check("busy_ignore_lat", lat_last, 1);
        repeat (200) @(negedge clk);
        check("busy_ignore_starts", ss_cnt - base, 1);

        start_campaign(1, 0);
        wait_ss(ok);
        repeat (3) @(negedge clk);
        send_done = 1'b1;
        @(negedge clk);
        send_done = 1'b0;
        repeat (50) @(negedge clk);
        dc = done_cnt;
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_busy", busy, 0);
        check("midrst_send_start", send_start, 0);
        check("midrst_done", done, 0);
        check("midrst_tmo", timeout_err, 0);
        check("midrst_lat_min", lat_min, 32'hFFFF_FFFF);
        check("midrst_lat_last", lat_last, 0);
        check("midrst_lat_sum", lat_sum, 0);
        check("midrst_runs", runs_done, 0);
        rst_n = 1'b1;
        repeat (300) @(negedge clk);
        check("midrst_no_done", done_cnt - dc, 0);
        check("sb_drain", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
